// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit controller.
//   - parity mode encodings as driven on cfg_parity_i
//   - serializer FSM state encoding
//   - data-bit limits and the clamp applied to the configured width
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  // Configured width below the UART minimum is raised to 5, above the
  // datapath width is lowered to that width.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg,
                                                 input logic [3:0] max_bits);
    if (cfg < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (cfg > max_bits) return max_bits;
    return cfg;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frame FSM for one UART character.
//   Latches data and configuration in LOAD, then shifts out start bit,
//   data bits (LSB first), optional parity and one or two stop bits.
//   Every bit period lasts max(baud_div,1) clocks, timed by a down-counter.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           strobe from the FIFO pop; accepted only in IDLE
//   data_i            popped character (valid in the LOAD cycle)
//   baud_div_i        clocks per bit, 0 treated as 1
//   data_bits_i       data bits per frame (clamped 5..DATA_W)
//   parity_i          PAR_NONE / PAR_EVEN / PAR_ODD (11 = none)
//   stop2_i           1 = two stop bits
//   tx_o              serial line, idle high
//   busy_o            state != IDLE
//   done_o            pulse on the last clock of the last stop bit
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | line high, waiting for start_i
// ST_LOAD   | latch frame data and config, preload bit timer
// ST_START  | drive start bit (0)
// ST_DATA   | shift out data bits LSB first
// ST_PARITY | drive parity bit (skipped when parity is none)
// ST_STOP   | drive stop bit(s) (1); done on the final clock
import uart_pkg::*;

module uart_tx_serializer #(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BAUD_W-1:0] baud_div_i,
  input  logic [3:0]        data_bits_i,
  input  logic [1:0]        parity_i,
  input  logic              stop2_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [3:0] MAX_BITS =
    4'((DATA_W > MAX_DATA_BITS) ? MAX_DATA_BITS : DATA_W);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bits_left_q, bits_left_d;
  logic              stop_left_q, stop_left_d;
  logic [1:0]        par_mode_q, par_mode_d;
  logic              par_acc_q, par_acc_d;

  logic bit_end;
  logic has_parity;

  // Timer reload value: a divider of 0 behaves like 1 (one clock per bit).
  function automatic logic [BAUD_W-1:0] reload(input logic [BAUD_W-1:0] div);
    return (div == '0) ? '0 : div - BAUD_W'(1);
  endfunction

  assign bit_end    = (cnt_q == '0);
  assign has_parity = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    baud_d      = baud_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    stop_left_d = stop_left_q;
    par_mode_d  = par_mode_q;
    par_acc_d   = par_acc_q;
    tx_o        = 1'b1;
    done_o      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d     = data_i;
        baud_d      = baud_div_i;
        par_mode_d  = parity_i;
        bits_left_d = clamp_data_bits(data_bits_i, MAX_BITS) - 4'd1;
        stop_left_d = stop2_i;
        par_acc_d   = 1'b0;
        cnt_d       = reload(baud_div_i);
        state_d     = ST_START;
      end
      ST_START: begin
        tx_o = 1'b0;
        if (bit_end) begin
          cnt_d   = reload(baud_q);
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        tx_o = shift_q[0];
        if (bit_end) begin
          cnt_d     = reload(baud_q);
          par_acc_d = par_acc_q ^ shift_q[0];
          shift_d   = shift_q >> 1;
          if (bits_left_q == 4'd0) begin
            state_d = has_parity ? ST_PARITY : ST_STOP;
          end else begin
            bits_left_d = bits_left_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        tx_o = par_acc_q ^ (par_mode_q == PAR_ODD);
        if (bit_end) begin
          cnt_d   = reload(baud_q);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!stop_left_q) begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_left_d = 1'b0;
            cnt_d       = reload(baud_q);
          end
        end else begin
          cnt_d = cnt_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      baud_q      <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      stop_left_q <= 1'b0;
      par_mode_q  <= PAR_NONE;
      par_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      baud_q      <= baud_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      stop_left_q <= stop_left_d;
      par_mode_q  <= par_mode_d;
      par_acc_q   <= par_acc_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit controller with write FIFO and configurable
// frame format (5..DATA_W data bits, none/even/odd parity, 1 or 2 stops).
// Optional build macro: UART_TX_CTS_EN -- when defined, cts_n_i is
// synchronised through two flops and a frame is only popped while it is low.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   baud_div_i          clocks per bit (0 treated as 1)
//   cfg_data_bits_i     data bits per frame
//   cfg_parity_i        00 none, 01 even, 10 odd, 11 none
//   cfg_stop2_i         1 = two stop bits
//   tx_en_i             allow new frames to start
//   wr_en_i, wdata_i    FIFO push
//   clr_ovf_i           clear sticky overflow flag
//   cts_n_i             clear-to-send, active low
//   full_o, empty_o, level_o  FIFO status (registered)
//   ovf_o               sticky: push attempted while full
//   busy_o              frame in progress
//   done_tick_o         one-cycle pulse at end of frame
//   tx_o                serial output, idle high
import uart_pkg::*;

module uart_tx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BAUD_W-1:0]             baud_div_i,
  input  logic [3:0]                    cfg_data_bits_i,
  input  logic [1:0]                    cfg_parity_i,
  input  logic                          cfg_stop2_i,
  input  logic                          tx_en_i,
  input  logic                          wr_en_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          clr_ovf_i,
  input  logic                          cts_n_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  output logic                          busy_o,
  output logic                          done_tick_o,
  output logic                          tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;

  logic push;
  logic pop;
  logic cts_ok;
  logic ser_busy;

`ifdef UART_TX_CTS_EN
  logic cts_meta_q, cts_meta_d;
  logic cts_sync_q, cts_sync_d;

  always_comb begin
    cts_meta_d = cts_n_i;
    cts_sync_d = cts_meta_q;
  end

  // Reset to "not clear" so nothing pops before the line has been sampled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_meta_d;
      cts_sync_q <= cts_sync_d;
    end
  end

  assign cts_ok = ~cts_sync_q;
`else
  logic unused_cts;
  assign unused_cts = cts_n_i;
  assign cts_ok     = 1'b1;
`endif

  // Full is taken from the registered flag, so a push while full is dropped
  // even when a pop happens in the same cycle.
  assign push = wr_en_i && !full_q;
  assign pop  = !ser_busy && tx_en_i && !empty_q && cts_ok;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wdata_i;

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    full_d     = (level_d == LW'(FIFO_DEPTH));
    empty_d    = (level_d == '0);
    pop_data_d = pop ? mem_q[rd_ptr_q] : pop_data_q;

    ovf_d = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (wr_en_i && full_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      pop_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      pop_data_q <= pop_data_d;
    end
  end

  uart_tx_serializer #(
    .DATA_W (DATA_W),
    .BAUD_W (BAUD_W)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (pop),
    .data_i      (pop_data_q),
    .baud_div_i  (baud_div_i),
    .data_bits_i (cfg_data_bits_i),
    .parity_i    (cfg_parity_i),
    .stop2_i     (cfg_stop2_i),
    .tx_o        (tx_o),
    .busy_o      (ser_busy),
    .done_o      (done_tick_o)
  );

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = ser_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] baud_div_i;
  logic [3:0]  cfg_data_bits_i;
  logic [1:0]  cfg_parity_i;
  logic        cfg_stop2_i;
  logic        tx_en_i;
  logic        wr_en_i;
  logic [7:0]  wdata_i;
  logic        clr_ovf_i;
  logic        cts_n_i;
  logic        full_o;
  logic        empty_o;
  logic [4:0]  level_o;
  logic        ovf_o;
  logic        busy_o;
  logic        done_tick_o;
  logic        tx_o;

  int tests = 0;
  int fails = 0;

  uart_tx_ctrl #(.DATA_W(8), .FIFO_DEPTH(16), .BAUD_W(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .baud_div_i      (baud_div_i),
    .cfg_data_bits_i (cfg_data_bits_i),
    .cfg_parity_i    (cfg_parity_i),
    .cfg_stop2_i     (cfg_stop2_i),
    .tx_en_i         (tx_en_i),
    .wr_en_i         (wr_en_i),
    .wdata_i         (wdata_i),
    .clr_ovf_i       (clr_ovf_i),
    .cts_n_i         (cts_n_i),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .level_o         (level_o),
    .ovf_o           (ovf_o),
    .busy_o          (busy_o),
    .done_tick_o     (done_tick_o),
    .tx_o            (tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en_i = 1'b1;
    wdata_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic set_cfg(input int bits, input int par, input int stop2, input int div);
    cfg_data_bits_i = 4'(bits);
    cfg_parity_i    = 2'(par);
    cfg_stop2_i     = 1'(stop2);
    baud_div_i      = 16'(div);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx_o !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_start_seen"}, 32'(tx_o === 1'b0), 32'd1);
  endtask

  // Called on the first clock of the start bit; walks the whole frame
  // against a waveform built from the byte and the format.
  task automatic run_frame(input string tag, input logic [8:0] data, input int nbits,
                           input int par, input int stop2, input int div);
    logic lv[$];
    logic p;
    int   eff;
    int   total;
    int   mism;
    int   dmis;
    eff  = (div == 0) ? 1 : div;
    p    = 1'b0;
    mism = 0;
    dmis = 0;
    lv.push_back(1'b0);
    for (int b = 0; b < nbits; b++) begin
      lv.push_back(data[b]);
      p ^= data[b];
    end
    if (par == 1) lv.push_back(p);
    if (par == 2) lv.push_back(~p);
    lv.push_back(1'b1);
    if (stop2 != 0) lv.push_back(1'b1);
    total = lv.size() * eff;
    for (int k = 0; k < total; k++) begin
      if (tx_o !== lv[k / eff]) mism++;
      if (done_tick_o !== (k == total - 1)) dmis++;
      tick();
    end
    check({tag, "_tx_wave"}, 32'(mism), 32'd0);
    check({tag, "_done_tick"}, 32'(dmis), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] b2b [3];
    int         dmis;
    b2b[0] = 8'h3C;
    b2b[1] = 8'hC3;
    b2b[2] = 8'h5A;

    rst_i     = 1'b1;
    tx_en_i   = 1'b0;
    wr_en_i   = 1'b0;
    wdata_i   = 8'h00;
    clr_ovf_i = 1'b0;
    cts_n_i   = 1'b0;
    set_cfg(8, 0, 0, 4);
    tick(3);
    rst_i = 1'b0;

    check("rst_tx",    32'(tx_o),        32'd1);
    check("rst_full",  32'(full_o),      32'd0);
    check("rst_empty", 32'(empty_o),     32'd1);
    check("rst_level", 32'(level_o),     32'd0);
    check("rst_ovf",   32'(ovf_o),       32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_done",  32'(done_tick_o), 32'd0);

    // 8N1, baud 4, 0xA5 with exact pop-to-start latency
    tx_en_i = 1'b1;
    push(8'hA5);
    check("a5_level_after_push", 32'(level_o), 32'd1);
    check("a5_empty_after_push", 32'(empty_o), 32'd0);
    tick();
    check("a5_load_busy",  32'(busy_o),  32'd1);
    check("a5_load_tx",    32'(tx_o),    32'd1);
    check("a5_load_empty", 32'(empty_o), 32'd1);
    tick();
    check("a5_start_lat", 32'(tx_o), 32'd0);
    run_frame("a5_8n1", 9'h0A5, 8, 0, 0, 4);

    // 7E2 / 7O2, baud 2, 0x41; tx_en dropped mid-frame
    set_cfg(7, 1, 1, 2);
    push(8'h41);
    wait_start("7e2");
    run_frame("7e2", 9'h041, 7, 1, 1, 2);
    set_cfg(7, 2, 1, 2);
    push(8'h41);
    push(8'h41);
    wait_start("7o2");
    tx_en_i = 1'b0;
    run_frame("7o2", 9'h041, 7, 2, 1, 2);
    tick(6);
    check("txen_off_busy",  32'(busy_o),  32'd0);
    check("txen_off_level", 32'(level_o), 32'd1);

    // data-bit clamping, divider 0, config change mid-frame
    do_reset();
    set_cfg(2, 1, 0, 0);
    tx_en_i = 1'b1;
    push(8'hFF);
    wait_start("clamp5");
    set_cfg(15, 0, 0, 3);
    run_frame("clamp5", 9'h0FF, 5, 1, 0, 0);
    push(8'h81);
    wait_start("clamp8");
    run_frame("clamp8", 9'h081, 8, 0, 0, 3);

    // overflow with tx disabled, then drain in order
    do_reset();
    tx_en_i = 1'b0;
    set_cfg(8, 0, 0, 1);
    wr_en_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wdata_i = 8'(i + 1);
      tick();
    end
    wr_en_i = 1'b0;
    check("ovf_level", 32'(level_o), 32'd16);
    check("ovf_full",  32'(full_o),  32'd1);
    check("ovf_flag",  32'(ovf_o),   32'd1);
    check("ovf_empty", 32'(empty_o), 32'd0);
    wr_en_i   = 1'b1;
    wdata_i   = 8'hEE;
    clr_ovf_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    check("ovf_wins_clr", 32'(ovf_o),   32'd1);
    check("ovf_wins_lvl", 32'(level_o), 32'd16);
    tick();
    clr_ovf_i = 1'b0;
    check("ovf_cleared", 32'(ovf_o), 32'd0);
    tx_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_start($sformatf("drain%0d", i));
      run_frame($sformatf("drain%0d", i), 9'(i + 1), 8, 0, 0, 1);
    end
    check("drain_empty", 32'(empty_o), 32'd1);

    // back-to-back frames at baud 1 with a push+pop in the same cycle
    do_reset();
    tx_en_i = 1'b0;
    set_cfg(8, 0, 0, 1);
    push(b2b[0]);
    push(b2b[1]);
    tx_en_i = 1'b1;
    wr_en_i = 1'b1;
    wdata_i = b2b[2];
    tick();
    wr_en_i = 1'b0;
    check("push_pop_level", 32'(level_o), 32'd2);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        check("b2b_gap1", 32'(tx_o), 32'd1);
        tick();
        check("b2b_gap2", 32'(tx_o), 32'd1);
        check("b2b_level", 32'(level_o), 32'(2 - i));
        check("b2b_empty", 32'(empty_o), 32'(i == 2));
        tick();
      end
      check("b2b_start", 32'(tx_o), 32'd0);
      run_frame($sformatf("b2b%0d", i), {1'b0, b2b[i]}, 8, 0, 0, 1);
    end

    // reset in the middle of data bit 3
    do_reset();
    tx_en_i = 1'b0;
    set_cfg(8, 0, 0, 4);
    push(8'hA5);
    push(8'h3C);
    tx_en_i = 1'b1;
    wait_start("midrst");
    check("midrst_level", 32'(level_o), 32'd1);
    tick(17);
    check("midrst_bit3", 32'(tx_o), 32'd0);
    rst_i   = 1'b1;
    tx_en_i = 1'b0;
    tick();
    rst_i = 1'b0;
    check("midrst_tx",    32'(tx_o),    32'd1);
    check("midrst_busy",  32'(busy_o),  32'd0);
    check("midrst_level", 32'(level_o), 32'd0);
    check("midrst_empty", 32'(empty_o), 32'd1);
    dmis = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_tick_o !== 1'b0 || tx_o !== 1'b1) dmis++;
      tick();
    end
    check("midrst_quiet", 32'(dmis), 32'd0);

`ifdef UART_TX_CTS_EN
    do_reset();
    set_cfg(8, 0, 0, 1);
    cts_n_i = 1'b1;
    tx_en_i = 1'b1;
    push(8'h55);
    tick(5);
    check("cts_hold_busy",  32'(busy_o),  32'd0);
    check("cts_hold_level", 32'(level_o), 32'd1);
    cts_n_i = 1'b0;
    tick(2);
    check("cts_sync_busy", 32'(busy_o), 32'd0);
    tick();
    check("cts_load_busy", 32'(busy_o), 32'd1);
    tick();
    check("cts_start", 32'(tx_o), 32'd0);
    run_frame("cts", 9'h055, 8, 0, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Parametrised UART transmit controller: write-side FIFO, frame serializer with runtime-configurable data bits, parity and stop bits, and an integrated per-bit baud counter.
Successor to the fixed 8N1 TX top; sits behind the peripheral register decoder, which drives the write strobe and config fields and reads the status outputs.
One clock; reset is synchronous and active-high.

Parameters:
DATA_W, 8, maximum data bits per frame (legal 5..9); FIFO entry width
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)
BAUD_W, 16, width of baud divider

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
baud_div_i  in  BAUD_W  clocks per bit; 0 treated as 1
cfg_data_bits_i  in  4  data bits per frame; <5 -> 5, >DATA_W -> DATA_W
cfg_parity_i  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2_i  in  1  1 = two stop bits
tx_en_i  in  1  allows new frames to start
wr_en_i  in  1  push strobe
wdata_i  in  DATA_W  push data
clr_ovf_i  in  1  clears ovf_o
cts_n_i  in  1  clear-to-send, active low (used only with UART_TX_CTS_EN)
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
level_o  out  $clog2(FIFO_DEPTH)+1  entries held
ovf_o  out  1  sticky: write attempted while full
busy_o  out  1  frame in progress (state != IDLE)
done_tick_o  out  1  one-cycle pulse at end of frame
tx_o  out  1  serial output, idle high

Behaviour:
- Reset: tx_o=1, full_o=0, empty_o=1, level_o=0, ovf_o=0, busy_o=0, done_tick_o=0, FIFO pointers 0, FSM IDLE. Reset mid-frame aborts it; tx_o high the cycle after rst_i is sampled.
- Push: wr_en_i && !full_o at edge -> entry stored, level+1. wr_en_i && full_o -> data dropped, ovf_o=1 next cycle. clr_ovf_i clears ovf_o; same-cycle overflow wins (ovf_o stays 1).
- Push and pop same cycle: both happen, level unchanged. Full is judged on the pre-edge state (no write-through when full).
- FSM IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: if tx_en_i && !empty_o, pop the head entry; go LOAD.
- LOAD (1 cycle): latch popped data, baud_div, data-bit count, parity mode and stop count into the frame registers. Config changes mid-frame affect only the next frame.
- Each of START, DATA bits, PARITY and STOP bits holds tx_o for exactly max(baud_div,1) clocks via a down-counter.
- START drives 0. DATA sends bits LSB first, count per latched config; upper unused bits are ignored.
- PARITY: even = XOR of sent data bits; odd = inverted. Skipped when parity is none.
- STOP drives 1 for 1 or 2 bit periods. done_tick_o pulses on the last STOP clock, then IDLE.
- Latency: pop at cycle n; start bit on tx_o from cycle n+2. Back-to-back frames leave exactly 2 extra high clocks (IDLE+LOAD) after the stop bit(s).
- tx_en_i deasserted mid-frame: the current frame completes; no new pop.
- level_o, full_o and empty_o are registered and consistent with each other every cycle.

Optional Feature:
UART_TX_CTS_EN:
- Defined: cts_n_i passes through a 2-flop synchroniser. IDLE pops only when tx_en_i && !empty_o && synchronised cts_n==0. Deassertion mid-frame does not stop the current frame.
- Undefined: cts_n_i is ignored; no synchroniser logic.

Decomposition:
- Package uart_pkg: parity encodings (PAR_NONE, PAR_EVEN, PAR_ODD), FSM state localparams, min/max data-bit constants.
- Sub-module uart_tx_serializer: FSM, baud counter, bit counter, parity accumulation. Inputs: frame data and config plus a start strobe; outputs: tx, busy, done.
- FIFO is inline in the top.

Test Plan:
- baud_div=4, 8N1, write 0xA5, tx_en=1 -> tx_o: 0 for 4 clks, then 1,0,1,0,0,1,0,1 each 4 clks, then 1 for 4 clks; done_tick_o high on clock 40 of the frame; start bit 2 clks after pop.
- 7E2, baud_div=2, write 0x41 -> data 1,0,0,0,0,0,1, parity 0, two stop bits; frame 22 clks. Odd parity, same byte -> parity 1.
- tx_en=0, FIFO_DEPTH=16, 17 writes -> level_o=16, full_o=1, ovf_o=1, 17th dropped. Then clr_ovf_i -> ovf_o=0. Enable -> 16 frames in order.
- Three queued bytes, baud_div=1, 8N1 -> frames of 10 clks each separated by exactly 2 high clks; empty_o=1 after 3rd pop.
- rst_i pulse during DATA bit 3 -> next cycle tx_o=1, busy_o=0, level_o=0, empty_o=1; no done_tick_o.
- UART_TX_CTS_EN: cts_n_i=1 with data queued -> no pop. cts_n_i 1->0 -> pop 2 clks later (synchroniser), start bit 2 clks after that.
